matmul_sequencer: RTL and testbench

- Control FSM that sequences one matrix-multiply operation on the MAX_DIM x MAX_DIM systolic PE array.
- Sits between the APB slave (control register, start) and the PE array / operand feeders / scratchpad.
- On start it:
  - clears or bias-loads the accumulators;
  - issues the skewed operand-feed schedule;
  - drains the PE pipeline;
  - writes the result to the selected scratchpad target;
  - pulses EOP.

---
 rtl/matmul_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_matmul_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_sequencer.sv
// -----------------------------------------------------------------------------
// matmul_sequencer
//
// Control FSM that runs one matrix multiply on the MAX_DIM x MAX_DIM systolic
// PE array. On an accepted start it:
//   1. clears the accumulators, or preloads them with a bias matrix read from
//      the scratchpad;
//   2. issues the skewed operand-feed schedule;
//   3. drains the PE pipeline;
//   4. writes the result to a scratchpad slot;
//   5. pulses EOP.
//
// Ports:
//   clk_i, rst_n_i      clock (rising edge), asynchronous active-low reset
//   start_i             one-cycle start request
//   control_reg_i       [1]     bias enable
//                       [3:2]   bias source slot
//                       [5:4]   result slot
//                       [9:8]   N-1
//                       [11:10] K-1
//                       [13:12] M-1
//   busy_o, EOP_o       operation in progress / end-of-operation pulse
//   start_drop_o        start seen while busy (ignored)
//   pe_clear_o          zero accumulators
//   pe_load_bias_o      load scratchpad read data into accumulators
//   sp_rd_en_o/_sel_o   bias read strobe and slot
//   feed_en_o, step_o   feed schedule active and current step
//   a_valid_o           per-row A operand valid
//   b_valid_o           per-column B operand valid
//   sp_wr_en_o/_sel_o   result write strobe and slot
// -----------------------------------------------------------------------------
module matmul_sequencer #(
    parameter int DATA_WIDTH  = 8,
    parameter int BUS_WIDTH   = 32,
    parameter int SP_NTARGETS = 4,
    parameter int PE_LAT      = 1,
    parameter int MAX_DIM     = BUS_WIDTH / DATA_WIDTH,
    parameter int STEP_W      = $clog2(3 * MAX_DIM),
    parameter int SEL_W       = $clog2(SP_NTARGETS)
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               start_i,
    input  logic [15:0]        control_reg_i,
    output logic               busy_o,
    output logic               EOP_o,
    output logic               start_drop_o,
    output logic               pe_clear_o,
    output logic               sp_rd_en_o,
    output logic [SEL_W-1:0]   sp_rd_sel_o,
    output logic               pe_load_bias_o,
    output logic               feed_en_o,
    output logic [STEP_W-1:0]  step_o,
    output logic [MAX_DIM-1:0] a_valid_o,
    output logic [MAX_DIM-1:0] b_valid_o,
    output logic               sp_wr_en_o,
    output logic [SEL_W-1:0]   sp_wr_sel_o
);

    // One extra bit so that "index + K" never wraps in the valid comparisons.
    localparam int CW      = STEP_W + 1;
    localparam int DRAIN_W = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(PE_LAT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_BIAS,
        ST_COMPUTE,
        ST_DRAIN,
        ST_WB,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               bias_q, bias_d;
    logic [SEL_W-1:0]   bias_sel_q, bias_sel_d;
    logic [SEL_W-1:0]   res_sel_q, res_sel_d;
    logic [2:0]         m_q, m_d;
    logic [2:0]         k_q, k_d;
    logic [2:0]         n_q, n_d;
    // Final feed step, T-1 = (M-1)+(N-1)+(K-1), taken straight from the fields.
    logic [STEP_W-1:0]  last_step_q, last_step_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;

    // Reserved control bits have no function.
    logic unused_ctrl;
    assign unused_ctrl = ^{control_reg_i[15:14], control_reg_i[7:6], control_reg_i[0]};

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            bias_q      <= 1'b0;
            bias_sel_q  <= '0;
            res_sel_q   <= '0;
            m_q         <= '0;
            k_q         <= '0;
            n_q         <= '0;
            last_step_q <= '0;
            step_q      <= '0;
            drain_q     <= '0;
        end else begin
            state_q     <= state_d;
            bias_q      <= bias_d;
            bias_sel_q  <= bias_sel_d;
            res_sel_q   <= res_sel_d;
            m_q         <= m_d;
            k_q         <= k_d;
            n_q         <= n_d;
            last_step_q <= last_step_d;
            step_q      <= step_d;
            drain_q     <= drain_d;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_d     = state_q;
        bias_d      = bias_q;
        bias_sel_d  = bias_sel_q;
        res_sel_d   = res_sel_q;
        m_d         = m_q;
        k_d         = k_q;
        n_d         = n_q;
        last_step_d = last_step_q;
        step_d      = step_q;
        drain_d     = drain_q;

        case (state_q)
            ST_IDLE: begin
                // Config is captured only here, so starts seen while busy
                // cannot disturb the running operation.
                if (start_i) begin
                    state_d     = ST_CLEAR;
                    bias_d      = control_reg_i[1];
                    bias_sel_d  = control_reg_i[3:2];
                    res_sel_d   = control_reg_i[5:4];
                    m_d         = {1'b0, control_reg_i[13:12]} + 3'd1;
                    k_d         = {1'b0, control_reg_i[11:10]} + 3'd1;
                    n_d         = {1'b0, control_reg_i[9:8]} + 3'd1;
                    last_step_d = STEP_W'(control_reg_i[13:12])
                                + STEP_W'(control_reg_i[11:10])
                                + STEP_W'(control_reg_i[9:8]);
                    step_d      = '0;
                    drain_d     = '0;
                end
            end
            ST_CLEAR: begin
                state_d = bias_q ? ST_BIAS : ST_COMPUTE;
            end
            ST_BIAS: begin
                // Scratchpad data returns one cycle after the read strobe.
                state_d = ST_COMPUTE;
            end
            ST_COMPUTE: begin
                if (step_q == last_step_q) begin
                    state_d = ST_DRAIN;
                    step_d  = '0;
                    drain_d = '0;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = ST_WB;
                    drain_d = '0;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            ST_WB: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        busy_o         = (state_q != ST_IDLE);
        EOP_o          = (state_q == ST_DONE);
        pe_clear_o     = (state_q == ST_CLEAR) && !bias_q;
        sp_rd_en_o     = (state_q == ST_CLEAR) && bias_q;
        sp_rd_sel_o    = '0;
        pe_load_bias_o = (state_q == ST_BIAS);
        feed_en_o      = (state_q == ST_COMPUTE);
        step_o         = '0;
        sp_wr_en_o     = (state_q == ST_WB);
        sp_wr_sel_o    = '0;
        if (sp_rd_en_o) begin
            sp_rd_sel_o = bias_sel_q;
        end
        if (feed_en_o) begin
            step_o = step_q;
        end
        if (sp_wr_en_o) begin
            sp_wr_sel_o = res_sel_q;
        end
    end

    // Flagged in the same cycle as the ignored request.
    assign start_drop_o = start_i && (state_q != ST_IDLE);

    // Skewed feed: row/column gi carries data for steps gi .. gi+K-1.
    logic [CW-1:0] step_ext, m_ext, k_ext, n_ext;
    assign step_ext = CW'(step_q);
    assign m_ext    = CW'(m_q);
    assign k_ext    = CW'(k_q);
    assign n_ext    = CW'(n_q);

    genvar gi;
    generate
        for (gi = 0; gi < MAX_DIM; gi++) begin : g_valid
            localparam logic [CW-1:0] IDX = CW'(gi);
            assign a_valid_o[gi] = feed_en_o && (IDX < m_ext)
                                && (step_ext >= IDX) && (step_ext < IDX + k_ext);
            assign b_valid_o[gi] = feed_en_o && (IDX < n_ext)
                                && (step_ext >= IDX) && (step_ext < IDX + k_ext);
        end
    endgenerate

endmodule

// File: tb/tb_matmul_sequencer.sv
// -----------------------------------------------------------------------------
// tb_matmul_sequencer
//
// Directed bench for matmul_sequencer. A table of operations (control word,
// hand-computed EOP cycle, cycles at which a stray start is injected, chaining)
// is replayed; every cycle of each operation is compared against expected
// outputs. Extra hand-written sequences cover reset state and reset abort.
// -----------------------------------------------------------------------------
module tb_matmul_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] ctrl;

    logic       busy, eop, drop, pe_clear, rd_en, load_bias, feed, wr_en;
    logic [1:0] rd_sel, wr_sel;
    logic [3:0] step, a_valid, b_valid;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    matmul_sequencer dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .start_i        (start),
        .control_reg_i  (ctrl),
        .busy_o         (busy),
        .EOP_o          (eop),
        .start_drop_o   (drop),
        .pe_clear_o     (pe_clear),
        .sp_rd_en_o     (rd_en),
        .sp_rd_sel_o    (rd_sel),
        .pe_load_bias_o (load_bias),
        .feed_en_o      (feed),
        .step_o         (step),
        .a_valid_o      (a_valid),
        .b_valid_o      (b_valid),
        .sp_wr_en_o     (wr_en),
        .sp_wr_sel_o    (wr_sel)
    );

    typedef struct packed {
        logic       busy;
        logic       eop;
        logic       drop;
        logic       clr;
        logic       rd_en;
        logic [1:0] rd_sel;
        logic       ld;
        logic       feed;
        logic [3:0] step;
        logic [3:0] a;
        logic [3:0] b;
        logic       wr_en;
        logic [1:0] wr_sel;
    } outs_t;

    typedef struct {
        logic [15:0] ctrl;
        int          eop_c;   // cycle (edges after the start edge) where EOP is high
        int          drop1;   // cycle to inject an ignored start (-1 = none)
        int          drop2;
        bit          chain;   // start the next entry in the first IDLE cycle
        bit          pre;     // already started by the previous entry
    } op_t;

    op_t ops[6];

    // Feed pattern for M=2, K=3, N=4, indexed by step.
    logic [3:0] lit_a[7];
    logic [3:0] lit_b[7];

    function automatic outs_t get_act();
        outs_t r;
        r.busy   = busy;
        r.eop    = eop;
        r.drop   = drop;
        r.clr    = pe_clear;
        r.rd_en  = rd_en;
        r.rd_sel = rd_sel;
        r.ld     = load_bias;
        r.feed   = feed;
        r.step   = step;
        r.a      = a_valid;
        r.b      = b_valid;
        r.wr_en  = wr_en;
        r.wr_sel = wr_sel;
        return r;
    endfunction

    // Expected outputs c edges after the start edge (PE_LAT = 1).
    function automatic outs_t model(input logic [15:0] cr, input int c,
                                    input int eop_c, input bit inj);
        outs_t e;
        int m, k, n, t, cs, s;
        e  = '0;
        m  = int'(cr[13:12]) + 1;
        k  = int'(cr[11:10]) + 1;
        n  = int'(cr[9:8]) + 1;
        t  = m + n + k - 2;
        cs = cr[1] ? 2 : 1;
        e.busy = (c <= eop_c);
        e.eop  = (c == eop_c);
        e.drop = inj;
        if (c == 0) begin
            if (cr[1]) begin
                e.rd_en  = 1'b1;
                e.rd_sel = cr[3:2];
            end else begin
                e.clr = 1'b1;
            end
        end
        if (cr[1] && c == 1) e.ld = 1'b1;
        if (c >= cs && c < cs + t) begin
            s      = c - cs;
            e.feed = 1'b1;
            e.step = 4'(s);
            for (int i = 0; i < 4; i++) begin
                e.a[i] = (i < m) && (s >= i) && (s < i + k);
                e.b[i] = (i < n) && (s >= i) && (s < i + k);
            end
        end
        if (c == cs + t + 1) begin
            e.wr_en  = 1'b1;
            e.wr_sel = cr[5:4];
        end
        return e;
    endfunction

    task automatic check(input string name, input int c, input outs_t act, input outs_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s c=%0d actual=%h required=%h", name, c, act, exp);
        end
    endtask

    task automatic check_val(input string name, input int c, input logic [7:0] act,
                             input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s c=%0d actual=%h required=%h", name, c, act, exp);
        end
    endtask

    // Replays one table entry. Entry is at posedge+1 on return.
    task automatic run_op(input int idx);
        op_t op;
        op = ops[idx];
        if (!op.pre) begin
            @(posedge clk); #1;
            start = 1'b1;
            ctrl  = op.ctrl;
            @(negedge clk);
            check("start_in_idle", -1, get_act(), outs_t'(0));
            @(posedge clk); #1;   // start edge e0
        end
        for (int c = 0; c <= op.eop_c + 1; c++) begin
            bit inj;
            inj = (c == op.drop1) || (c == op.drop2);
            if (op.chain && c == op.eop_c + 1 && idx + 1 < 6) begin
                start = 1'b1;
                ctrl  = ops[idx + 1].ctrl;
            end else begin
                start = inj;
                ctrl  = inj ? 16'hFFFF : op.ctrl;
            end
            @(negedge clk);
            check($sformatf("op%0d", idx), c, get_act(), model(op.ctrl, c, op.eop_c, inj));
            if (idx == 2 && c >= 1 && c <= 7)
                check_val("lit_ab", c, {a_valid, b_valid}, {lit_a[c - 1], lit_b[c - 1]});
            @(posedge clk); #1;
        end
        start = 1'b0;
        ctrl  = 16'h0000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        ops[0] = '{16'h3F00, 13, -1, -1, 1'b0, 1'b0};  // 4x4x4, clear
        ops[1] = '{16'h003A,  5, -1, -1, 1'b0, 1'b0};  // 1x1x1, bias slot 2, result 3
        ops[2] = '{16'hDBC1, 10, -1, -1, 1'b0, 1'b0};  // M2 K3 N4 + reserved bits
        ops[3] = '{16'h1526,  8,  3,  8, 1'b0, 1'b0};  // drops in COMPUTE and DONE
        ops[4] = '{16'h0000,  4, -1, -1, 1'b1, 1'b0};  // back-to-back first
        ops[5] = '{16'h2710, 10, -1, -1, 1'b0, 1'b1};  // back-to-back second

        lit_a[0] = 4'b0001; lit_a[1] = 4'b0011; lit_a[2] = 4'b0011; lit_a[3] = 4'b0010;
        lit_a[4] = 4'b0000; lit_a[5] = 4'b0000; lit_a[6] = 4'b0000;
        lit_b[0] = 4'b0001; lit_b[1] = 4'b0011; lit_b[2] = 4'b0111; lit_b[3] = 4'b1110;
        lit_b[4] = 4'b1100; lit_b[5] = 4'b1000; lit_b[6] = 4'b0000;

        rst_n = 1'b0;
        start = 1'b0;
        ctrl  = 16'h0000;
        #3;
        check("reset_state", -1, get_act(), outs_t'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_op(i);
        end

        // Reset abort during COMPUTE step 4.
        @(posedge clk); #1;
        start = 1'b1;
        ctrl  = 16'h3F00;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_val("pre_abort_step", 5, {4'b0, step}, 8'd4);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_async", 5, get_act(), outs_t'(0));
        @(negedge clk);
        check("abort_hold", 6, get_act(), outs_t'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check("abort_idle", c, get_act(), outs_t'(0));
        end
        @(posedge clk); #1;
        run_op(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
